kpd_digit_entry: RTL and testbench
==================================

KPD_DIGIT_ENTRY -- requirements
Module: kpd_digit_entry

Interface
REQ-001 Parameter TIMEOUT_CYC, default 250000000, inactivity limit in CLK_50M cycles (5 s); used only when KPD_TIMEOUT_EN is defined.
REQ-002 CLK_50M  in  1  system clock; all logic on rising edge.
REQ-003 RST  in  1  reset, synchronous and active-high.
REQ-004 KPD_down  in  1  one-cycle debounced key-press pulse from keypad scanner.
REQ-005 KPD_up  in  1  one-cycle debounced key-release pulse from keypad scanner.
REQ-006 KPD_value  in  4  key code: 0-9 digit, 0xA clear, 0xB enter, 0xF none/invalid; sampled only in the cycle KPD_down is high.
REQ-007 ENT_data  out  16  four packed BCD digits, newest digit in [3:0].
REQ-008 ENT_count  out  3  digits held, 0-4.
REQ-009 ENT_valid  out  1  entry complete, ENT_data frozen.
REQ-010 ENT_ready  in  1  consumer accepts entry when high together with ENT_valid.
REQ-011 ENT_error  out  1  one-cycle pulse on rejected key.
REQ-012 ENT_timeout  out  1  one-cycle pulse on inactivity clear.

Function
REQ-013 FSM states: IDLE (accepting keys), HELD (key down, awaiting release), DONE (entry offered).
REQ-014 KPD_down is evaluated only in IDLE; KPD_up only in HELD; in DONE, both only update the internal pressed flag.
REQ-015 Pressed flag: set on KPD_down, cleared on KPD_up, in every state.
REQ-016 IDLE, KPD_down, digit 0-9, ENT_count<4: ENT_data <= {ENT_data[11:0], KPD_value}; ENT_count +1; next state HELD.
REQ-017 IDLE, KPD_down, digit, ENT_count=4: data/count unchanged; ENT_error pulses; next state HELD.
REQ-018 IDLE, KPD_down, 0xA: ENT_data <= 0; ENT_count <= 0; next state HELD.
REQ-019 IDLE, KPD_down, 0xB, ENT_count>0: ENT_valid <= 1; next state DONE.
REQ-020 IDLE, KPD_down, 0xB, ENT_count=0: ENT_error pulses; next state HELD.
REQ-021 IDLE, KPD_down, any other code (0xC-0xF): ignored, no error; next state HELD.
REQ-022 HELD, KPD_up: next state IDLE.
REQ-023 DONE: ENT_valid held high, ENT_data/ENT_count frozen until ENT_valid && ENT_ready.
REQ-024 Handshake cycle: next cycle ENT_valid=0, ENT_data=0, ENT_count=0; next state HELD if pressed flag set (including set the same cycle), else IDLE.
REQ-025 Latency: outputs reflect a KPD_down event on the following clock edge (one cycle); ENT_error/ENT_timeout are registered, high exactly one cycle.
REQ-026 ENT_valid cannot rise in the same cycle ENT_error pulses.

Reset
REQ-027 RST high at a clock edge: state IDLE, pressed flag 0, ENT_data 0, ENT_count 0, ENT_valid 0, ENT_error 0, ENT_timeout 0, timeout counter 0; overrides all other inputs, including mid-entry and in DONE.

Configuration
REQ-028 Macro KPD_TIMEOUT_EN defined: 32-bit counter runs in IDLE/HELD while ENT_count>0; cleared on any KPD_down, on reset, when ENT_count=0, and in DONE.
REQ-029 Counter reaching TIMEOUT_CYC-1: ENT_data <= 0, ENT_count <= 0, ENT_timeout pulses, counter cleared; state unchanged.
REQ-030 Macro undefined: no counter is built; ENT_timeout is tied to 0.

Verification
REQ-031 Keys 1,2,3,0xB (each down/up) -> ENT_data=0x0123, ENT_count=3, ENT_valid=1; ENT_ready=1 -> next cycle ENT_valid=0, ENT_data=0.
REQ-032 Keys 9,8,7,6,5 -> fifth key: ENT_error one cycle, ENT_data=0x9876, ENT_count=4.
REQ-033 Keys 4,0xA,0xB -> clear gives ENT_count=0; enter gives ENT_error, ENT_valid stays 0.
REQ-034 Second KPD_down while in HELD (no KPD_up) -> ignored, ENT_data unchanged.
REQ-035 RST asserted in DONE with ENT_ready=0 -> next cycle ENT_valid=0, ENT_count=0, state IDLE.
REQ-036 With KPD_TIMEOUT_EN, TIMEOUT_CYC=100: key 5, then idle 100 cycles -> ENT_timeout pulse, ENT_count=0; without macro ENT_timeout stays 0.

Source files
------------

// File: rtl/kpd_digit_entry.sv
// rtl/kpd_digit_entry.sv - keypad digit entry: collects up to four BCD digits and offers them with a valid/ready handshake
//
// Optional inactivity clear is built only when KPD_TIMEOUT_EN is defined.
//
// Ports:
//   CLK_50M      in   system clock, rising edge
//   RST          in   synchronous active-high reset
//   KPD_down     in   one-cycle key-press pulse
//   KPD_up       in   one-cycle key-release pulse
//   KPD_value    in   [3:0] key code (0-9 digit, A clear, B enter, C-F ignored)
//   ENT_data     out  [15:0] packed BCD digits, newest in [3:0]
//   ENT_count    out  [2:0] number of digits held (0-4)
//   ENT_valid    out  entry offered, data frozen until accepted
//   ENT_ready    in   consumer accepts entry when high with ENT_valid
//   ENT_error    out  one-cycle pulse on a rejected key
//   ENT_timeout  out  one-cycle pulse when the entry is cleared for inactivity
module kpd_digit_entry #(
    parameter int unsigned TIMEOUT_CYC = 250000000
) (
    input  logic        CLK_50M,
    input  logic        RST,
    input  logic        KPD_down,
    input  logic        KPD_up,
    input  logic [3:0]  KPD_value,
    output logic [15:0] ENT_data,
    output logic [2:0]  ENT_count,
    output logic        ENT_valid,
    input  logic        ENT_ready,
    output logic        ENT_error,
    output logic        ENT_timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        pressed_q, pressed_d;
    logic [15:0] data_q, data_d;
    logic [2:0]  count_q, count_d;
    logic        valid_q, valid_d;
    logic        error_q, error_d;

`ifdef KPD_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        timeout_q, timeout_d;
`else
    logic [31:0] unused_timeout_cyc;
    assign unused_timeout_cyc = TIMEOUT_CYC;
`endif

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        count_d   = count_q;
        valid_d   = valid_q;
        error_d   = 1'b0;
        // Press wins if press and release coincide: the key is considered down.
        pressed_d = KPD_down ? 1'b1 : (KPD_up ? 1'b0 : pressed_q);

        case (state_q)
            IDLE: begin
                if (KPD_down) begin
                    state_d = HELD;
                    if (KPD_value <= 4'd9) begin
                        if (count_q < 3'd4) begin
                            data_d  = {data_q[11:0], KPD_value};
                            count_d = count_q + 3'd1;
                        end else begin
                            error_d = 1'b1;
                        end
                    end else if (KPD_value == 4'hA) begin
                        data_d  = 16'h0000;
                        count_d = 3'd0;
                    end else if (KPD_value == 4'hB) begin
                        if (count_q != 3'd0) begin
                            valid_d = 1'b1;
                            state_d = DONE;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
            end
            HELD: begin
                if (KPD_up) begin
                    state_d = IDLE;
                end
            end
            DONE: begin
                if (valid_q && ENT_ready) begin
                    valid_d = 1'b0;
                    data_d  = 16'h0000;
                    count_d = 3'd0;
                    // A key still down (or going down now) must be released
                    // before the next entry starts.
                    state_d = pressed_d ? HELD : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef KPD_TIMEOUT_EN
    always_comb begin
        tmo_cnt_d = 32'd0;
        timeout_d = 1'b0;
        if (state_q != DONE && count_q != 3'd0 && !KPD_down) begin
            if (tmo_cnt_q == TMO_LAST) begin
                timeout_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
            end
        end
    end

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            tmo_cnt_q <= 32'd0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign ENT_timeout = timeout_q;
`else
    assign ENT_timeout = 1'b0;
`endif

    always_ff @(posedge CLK_50M) begin
        if (RST) begin
            state_q   <= IDLE;
            pressed_q <= 1'b0;
            data_q    <= 16'h0000;
            count_q   <= 3'd0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pressed_q <= pressed_d;
            error_q   <= error_d;
            valid_q   <= valid_d;
`ifdef KPD_TIMEOUT_EN
            // Inactivity clear only happens outside DONE, so valid is unaffected.
            if (timeout_d) begin
                data_q  <= 16'h0000;
                count_q <= 3'd0;
            end else begin
                data_q  <= data_d;
                count_q <= count_d;
            end
`else
            data_q    <= data_d;
            count_q   <= count_d;
`endif
        end
    end

    assign ENT_data  = data_q;
    assign ENT_count = count_q;
    assign ENT_valid = valid_q;
    assign ENT_error = error_q;

endmodule

// File: tb/tb_kpd_digit_entry.sv
// tb/tb_kpd_digit_entry.sv - scoreboard bench for kpd_digit_entry
module tb_kpd_digit_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        kpd_down = 1'b0;
    logic        kpd_up = 1'b0;
    logic [3:0]  kpd_value = 4'hF;
    logic        ent_ready = 1'b0;
    logic [15:0] ent_data;
    logic [2:0]  ent_count;
    logic        ent_valid;
    logic        ent_error;
    logic        ent_timeout;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cy;
        string       nm;
        logic [15:0] d;
        logic [2:0]  c;
        logic        v;
        logic        e;
        logic        t;
    } exp_t;

    exp_t exp_q[$];

    kpd_digit_entry #(.TIMEOUT_CYC(100)) dut (
        .CLK_50M    (clk),
        .RST        (rst),
        .KPD_down   (kpd_down),
        .KPD_up     (kpd_up),
        .KPD_value  (kpd_value),
        .ENT_data   (ent_data),
        .ENT_count  (ent_count),
        .ENT_valid  (ent_valid),
        .ENT_ready  (ent_ready),
        .ENT_error  (ent_error),
        .ENT_timeout(ent_timeout)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic exp_at(input int cy, input string nm, input logic [15:0] d,
                          input logic [2:0] c, input logic v, input logic e, input logic t);
        exp_t x;
        x.cy = cy; x.nm = nm; x.d = d; x.c = c; x.v = v; x.e = e; x.t = t;
        exp_q.push_back(x);
    endtask

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Monitor: pops every expectation due at this cycle and compares outputs.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cy <= cyc) begin
                x = exp_q.pop_front();
                if (x.cy < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s missed expectation cycle=%0d now=%0d", x.nm, x.cy, cyc);
                end else begin
                    chk({x.nm, ".data"},    int'(ent_data),    int'(x.d));
                    chk({x.nm, ".count"},   int'(ent_count),   int'(x.c));
                    chk({x.nm, ".valid"},   int'(ent_valid),   int'(x.v));
                    chk({x.nm, ".error"},   int'(ent_error),   int'(x.e));
                    chk({x.nm, ".timeout"}, int'(ent_timeout), int'(x.t));
                end
            end
        end
    end

    // Full key stroke: down pulse, gap, up pulse. Expected state after the
    // press edge, and again one cycle later with the error pulse gone.
    task automatic key(input logic [3:0] v, input logic [15:0] d, input logic [2:0] c,
                       input logic ev, input logic ee, input string nm);
        @(negedge clk);
        kpd_down = 1'b1; kpd_value = v;
        exp_at(cyc + 1, nm, d, c, ev, ee, 1'b0);
        @(negedge clk);
        kpd_down = 1'b0; kpd_value = 4'hF;
        exp_at(cyc + 1, {nm, "_after"}, d, c, ev, 1'b0, 1'b0);
        @(negedge clk);
        kpd_up = 1'b1;
        @(negedge clk);
        kpd_up = 1'b0;
    endtask

    initial begin
        int d0;
        // Reset state
        repeat (3) @(negedge clk);
        exp_at(cyc + 1, "reset", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Entry 1,2,3 then enter, keys ignored in DONE, then handshake
        key(4'h1, 16'h0001, 3'd1, 1'b0, 1'b0, "k1");
        key(4'h2, 16'h0012, 3'd2, 1'b0, 1'b0, "k2");
        key(4'h3, 16'h0123, 3'd3, 1'b0, 1'b0, "k3");
        key(4'hB, 16'h0123, 3'd3, 1'b1, 1'b0, "enter");
        key(4'h7, 16'h0123, 3'd3, 1'b1, 1'b0, "done_key");
        @(negedge clk);
        ent_ready = 1'b1;
        exp_at(cyc + 1, "handshake", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        ent_ready = 1'b0;

        // Overflow on fifth digit
        key(4'h9, 16'h0009, 3'd1, 1'b0, 1'b0, "k9");
        key(4'h8, 16'h0098, 3'd2, 1'b0, 1'b0, "k8");
        key(4'h7, 16'h0987, 3'd3, 1'b0, 1'b0, "k7");
        key(4'h6, 16'h9876, 3'd4, 1'b0, 1'b0, "k6");
        key(4'h5, 16'h9876, 3'd4, 1'b0, 1'b1, "overflow");

        // Clear, digit, clear, enter on empty, ignored code
        key(4'hA, 16'h0000, 3'd0, 1'b0, 1'b0, "clr1");
        key(4'h4, 16'h0004, 3'd1, 1'b0, 1'b0, "k4");
        key(4'hA, 16'h0000, 3'd0, 1'b0, 1'b0, "clr2");
        key(4'hB, 16'h0000, 3'd0, 1'b0, 1'b1, "enter_empty");
        key(4'hC, 16'h0000, 3'd0, 1'b0, 1'b0, "code_c");

        // Second press while HELD is ignored
        @(negedge clk);
        kpd_down = 1'b1; kpd_value = 4'h2;
        exp_at(cyc + 1, "held_first", 16'h0002, 3'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        kpd_down = 1'b0;
        @(negedge clk);
        kpd_down = 1'b1; kpd_value = 4'h3;
        exp_at(cyc + 1, "held_second", 16'h0002, 3'd1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        kpd_down = 1'b0;
        @(negedge clk);
        kpd_up = 1'b1;
        @(negedge clk);
        kpd_up = 1'b0;
        key(4'h5, 16'h0025, 3'd2, 1'b0, 1'b0, "after_held");

        // Handshake with a press in the same cycle goes to HELD
        key(4'hB, 16'h0025, 3'd2, 1'b1, 1'b0, "enter2");
        @(negedge clk);
        kpd_down = 1'b1; kpd_value = 4'h4; ent_ready = 1'b1;
        exp_at(cyc + 1, "hs_pressed", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        kpd_down = 1'b0; ent_ready = 1'b0;
        exp_at(cyc + 1, "hs_pressed_hold", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        kpd_down = 1'b1; kpd_value = 4'h6;
        exp_at(cyc + 1, "hs_held_ignore", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        kpd_down = 1'b0;
        @(negedge clk);
        kpd_up = 1'b1;
        @(negedge clk);
        kpd_up = 1'b0;
        key(4'h6, 16'h0006, 3'd1, 1'b0, 1'b0, "k6b");

        // Reset while in DONE
        key(4'hB, 16'h0006, 3'd1, 1'b1, 1'b0, "enter3");
        @(negedge clk);
        rst = 1'b1;
        exp_at(cyc + 1, "rst_done", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        key(4'h7, 16'h0007, 3'd1, 1'b0, 1'b0, "after_rst");

        // Inactivity: press 5, release, then idle
        @(negedge clk);
        d0 = cyc + 1;
        kpd_down = 1'b1; kpd_value = 4'h5;
        exp_at(d0, "tmo_key", 16'h0075, 3'd2, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        kpd_down = 1'b0;
        @(negedge clk);
        kpd_up = 1'b1;
        @(negedge clk);
        kpd_up = 1'b0;
        exp_at(d0 + 99, "tmo_before", 16'h0075, 3'd2, 1'b0, 1'b0, 1'b0);
`ifdef KPD_TIMEOUT_EN
        exp_at(d0 + 100, "tmo_pulse", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b1);
        exp_at(d0 + 101, "tmo_after", 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0);
`else
        exp_at(d0 + 100, "tmo_none", 16'h0075, 3'd2, 1'b0, 1'b0, 1'b0);
        exp_at(d0 + 101, "tmo_none2", 16'h0075, 3'd2, 1'b0, 1'b0, 1'b0);
`endif
        repeat (110) @(negedge clk);

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
